ram_fifo_ctrl: RTL

- Synchronous FIFO controller that sits directly upstream of the team's simple dual-port RAM and turns it into a first-in/first-out buffer.
- Converts producer `push` and consumer `pop` requests into the RAM's `wr_en`/`rd_en`/`blk_select`, write address and read address.
- Tracks occupancy and flags and marks the cycle when RAM `dout` holds popped data.
- Data never passes through this block: the producer drives RAM `din` directly, and the consumer samples RAM `dout`.

---
 rtl/ram_fifo_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller that drives a simple dual-port RAM; data never passes through here.
// Latency: RAM dout holds the popped word one cycle after the accepted pop (rd_valid_o marks it).
// Backpressure: push is refused while full and pop while empty; refused requests change nothing.
// Optional sticky overflow/underflow flags are built only when FIFO_ERR_FLAGS_EN is defined.
module ram_fifo_ctrl #(
    parameter int MEM_DEPTH  = 1024,
    parameter int ADDER_SIZE = 10,
    parameter int AF_LEVEL   = MEM_DEPTH - 4,
    parameter int AE_LEVEL   = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic                  clr_err_i,
    output logic                  ram_wr_en_o,
    output logic                  ram_rd_en_o,
    output logic                  ram_blk_select_o,
    output logic [ADDER_SIZE-1:0] ram_addr_wr_o,
    output logic [ADDER_SIZE-1:0] ram_addr_rd_o,
    output logic                  rd_valid_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [ADDER_SIZE:0]   count_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam logic [ADDER_SIZE-1:0] LAST_ADDR = ADDER_SIZE'(MEM_DEPTH - 1);
    localparam logic [ADDER_SIZE-1:0] PTR_ONE   = ADDER_SIZE'(1);
    localparam logic [ADDER_SIZE:0]   CNT_ONE   = (ADDER_SIZE + 1)'(1);
    localparam logic [ADDER_SIZE:0]   CNT_DEPTH = (ADDER_SIZE + 1)'(MEM_DEPTH);
    localparam logic [ADDER_SIZE:0]   CNT_AF    = (ADDER_SIZE + 1)'(AF_LEVEL);
    localparam logic [ADDER_SIZE:0]   CNT_AE    = (ADDER_SIZE + 1)'(AE_LEVEL);

    logic [ADDER_SIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDER_SIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDER_SIZE:0]   count_q, count_d;
    logic                  full_q, empty_q, almost_full_q, almost_empty_q;
    logic                  rd_valid_q;
    logic                  push_ok, pop_ok;

    // Accept decisions use the registered flags, so push at full / pop at empty are refused
    assign push_ok = push_i & ~full_q;
    assign pop_ok  = pop_i & ~empty_q;

    assign ram_wr_en_o      = push_ok;
    assign ram_rd_en_o      = pop_ok;
    assign ram_blk_select_o = push_ok | pop_ok;
    assign ram_addr_wr_o    = wr_ptr_q;
    assign ram_addr_rd_o    = rd_ptr_q;

    // Next pointer and occupancy; wrap is an explicit compare so non-power-of-two depths work
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == LAST_ADDR) ? '0 : wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == LAST_ADDR) ? '0 : rd_ptr_q + PTR_ONE;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_ONE;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // Pointer, count and flag registers; flags derive from the next count so they track it exactly
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            rd_valid_q     <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            full_q         <= (count_d == CNT_DEPTH);
            empty_q        <= (count_d == '0);
            almost_full_q  <= (count_d >= CNT_AF);
            almost_empty_q <= (count_d <= CNT_AE);
            rd_valid_q     <= pop_ok;
        end
    end

    assign full_o         = full_q;
    assign empty_o        = empty_q;
    assign almost_full_o  = almost_full_q;
    assign almost_empty_o = almost_empty_q;
    assign count_o        = count_q;
    assign rd_valid_o     = rd_valid_q;

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q, underflow_q;

    // Sticky error flags; a new error in the same cycle as clr_err keeps the flag set
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= (overflow_q & ~clr_err_i) | (push_i & full_q);
            underflow_q <= (underflow_q & ~clr_err_i) | (pop_i & empty_q);
        end
    end

    assign overflow_o  = overflow_q;
    assign underflow_o = underflow_q;
`else
    logic unused_clr_err;

    assign unused_clr_err = clr_err_i;
    assign overflow_o     = 1'b0;
    assign underflow_o    = 1'b0;
`endif

endmodule
